// File: rtl/grid_access_arbiter_pkg.sv
// Shared opcodes, free-cell marker and sequencer state encoding for the
// grid access arbiter.
package grid_access_arbiter_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CLAIM = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam int EMPTY = -1;

  typedef enum logic [2:0] {
    ARB, ISSUE, WAIT, CAPTURE, WR, DONE
  } state_t;

endpackage

// File: rtl/grid_access_arbiter_if.sv
// Worker-side request/ack bundle plus the single-port placement RAM pins.
interface grid_access_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][1:0]    op;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic [NREQ-1:0]         ack;
  logic [DW-1:0]           rdata;
  logic                    claim_ok;
  logic                    err;
  logic                    mem_read;
  logic                    mem_write;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_din;
  logic [DW-1:0]           mem_dout;

  modport master (
    output req, op, addr, wdata, mem_dout,
    input  ack, rdata, claim_ok, err, mem_read, mem_write, mem_addr, mem_din
  );

  modport slave (
    input  req, op, addr, wdata, mem_dout,
    output ack, rdata, claim_ok, err, mem_read, mem_write, mem_addr, mem_din
  );
endinterface

// File: rtl/grid_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last.
module grid_access_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            any
);
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end
endmodule

// File: rtl/grid_access_arbiter.sv
// Round-robin sequencer sharing one placement RAM among NREQ workers;
// supports READ, WRITE and an atomic read-test-write CLAIM.
module grid_access_arbiter
  import grid_access_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 36,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  grid_access_arbiter_if.slave  bus
);
  localparam int IW  = $clog2(NREQ);
  localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  state_t          state, state_n;
  logic [IW-1:0]   last, last_n, gnt;
  logic            any, bad, hit;
  logic [1:0]      op_q, op_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic            err_q, err_qn;
  logic [WCW-1:0]  wcnt, wcnt_n;
  logic            mem_read, mem_read_n, mem_write, mem_write_n;
  logic [AW-1:0]   mem_addr, mem_addr_n;
  logic [DW-1:0]   mem_din, mem_din_n;
  logic [NREQ-1:0] ack, ack_n;
  logic [DW-1:0]   rdata, rdata_n;
  logic            claim_ok, claim_ok_n, err, err_n;

  grid_access_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .last  (last),
    .grant (gnt),
    .any   (any)
  );

  assign bad = (bus.addr[gnt] >= AW'(DEPTH)) || (bus.op[gnt] == OP_RSVD);
  assign hit = (bus.mem_dout == DW'(EMPTY));

  always_comb begin
    state_n     = state;
    last_n      = last;
    op_n        = op_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    err_qn      = err_q;
    wcnt_n      = wcnt;
    mem_read_n  = 1'b0;
    mem_write_n = 1'b0;
    mem_addr_n  = mem_addr;
    mem_din_n   = mem_din;
    ack_n       = '0;
    rdata_n     = rdata;
    claim_ok_n  = claim_ok;
    err_n       = err;
    unique case (state)
      ARB: if (any) begin
        last_n  = gnt;
        op_n    = bus.op[gnt];
        addr_n  = bus.addr[gnt];
        wdata_n = bus.wdata[gnt];
        err_qn  = bad;
        // Rejected requests idle through the WR slot so their ack lands at t+2.
        if (bad) begin
          state_n = WR;
        end else if (bus.op[gnt] == OP_WRITE) begin
          state_n     = WR;
          mem_write_n = 1'b1;
          mem_addr_n  = bus.addr[gnt];
          mem_din_n   = bus.wdata[gnt];
        end else begin
          state_n    = ISSUE;
          mem_read_n = 1'b1;
          mem_addr_n = bus.addr[gnt];
        end
      end
      ISSUE: begin
        wcnt_n  = WCW'((RD_LAT > 2) ? RD_LAT - 2 : 0);
        state_n = (RD_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (wcnt == '0) state_n = CAPTURE;
        else            wcnt_n  = wcnt - 1'b1;
      end
      CAPTURE: begin
        rdata_n = bus.mem_dout;
        if (op_q == OP_CLAIM) begin
          // Write-back decided on the live read data; nobody else can interleave.
          state_n     = WR;
          mem_write_n = hit;
          claim_ok_n  = hit;
          mem_addr_n  = addr_q;
          mem_din_n   = wdata_q;
        end else begin
          state_n    = DONE;
          ack_n      = NREQ'(1) << last;
          claim_ok_n = 1'b0;
          err_n      = 1'b0;
        end
      end
      WR: begin
        state_n = DONE;
        ack_n   = NREQ'(1) << last;
        err_n   = err_q;
        if (err_q || op_q != OP_CLAIM) claim_ok_n = 1'b0;
      end
      DONE:    state_n = ARB;
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      last      <= IW'(NREQ - 1);
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      wcnt      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      ack       <= '0;
      rdata     <= '0;
      claim_ok  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      op_q      <= op_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      err_q     <= err_qn;
      wcnt      <= wcnt_n;
      mem_read  <= mem_read_n;
      mem_write <= mem_write_n;
      mem_addr  <= mem_addr_n;
      mem_din   <= mem_din_n;
      ack       <= ack_n;
      rdata     <= rdata_n;
      claim_ok  <= claim_ok_n;
      err       <= err_n;
    end
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = mem_din;
  assign bus.ack       = ack;
  assign bus.rdata     = rdata;
  assign bus.claim_ok  = claim_ok;
  assign bus.err       = err;
endmodule
